// File: rtl/extamp_fa_rx.sv
// rtl/extamp_fa_rx.sv - Elecraft "FA" command receiver for the external-amp band-control link
//
// Receives the 8N1 UART stream from the Hermes-Lite FA transmitter and parses
// "FAd10..d0;" commands (11 ASCII digits). The VFO-A frequency is presented in binary Hz
// and a band code is provided for the amplifier's filter and relay logic.
//
// Optional feature: define EXTAMP_BAND_DECODE_EN to build the band decoder.
// Without it, band is tied to 0.
//
// Ports:
//   clk        system clock (CLKFREQ Hz)
//   rst        synchronous active-high reset
//   uart_rxd   asynchronous serial input; polarity is selected by RX_INVERT
//   freq       last valid frequency in Hz
//   freq_valid one-cycle pulse when freq is reloaded
//   band       band code registered together with freq
//   frame_err  one-cycle pulse on a framing, parse or timeout error
//   err_cnt    saturating count of frame_err pulses
module extamp_fa_rx #(
    parameter int CLKFREQ      = 48000000,
    parameter int BAUDRATE     = 9600,
    parameter int RX_INVERT    = 1,
    parameter int TIMEOUT_CLKS = 48000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic [31:0] freq,
    output logic        freq_valid,
    output logic [3:0]  band,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam int BIT_CLKS = CLKFREQ / BAUDRATE;
    localparam int BCW      = $clog2(BIT_CLKS + 1);
    localparam int TCW      = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BCW-1:0] HALF_LOAD = BCW'(BIT_CLKS / 2 - 1);
    localparam logic [BCW-1:0] FULL_LOAD = BCW'(BIT_CLKS - 1);
    localparam logic [TCW-1:0] TO_MAX    = TCW'(TIMEOUT_CLKS);
    localparam logic           RX_INV    = (RX_INVERT != 0);

    // Receiver states
    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_STOP  = 3'd3;
    localparam logic [2:0] R_BRK   = 3'd4;  // bad stop bit: wait for the line to return to mark

    // Parser states
    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_A    = 2'd1;
    localparam logic [1:0] P_DIG  = 2'd2;
    localparam logic [1:0] P_END  = 2'd3;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rx_prev_q, rx_prev_d;
    logic rx;

    // After this XOR, rx=1 always means mark/idle, whatever the line polarity.
    assign rx = sync2_q ^ RX_INV;

    always_comb begin
        sync1_d   = uart_rxd;
        sync2_d   = sync1_q;
        rx_prev_d = rx;
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    logic [2:0]     r_state_q, r_state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           byte_valid_q, byte_valid_d;
    logic           stop_err;
    logic           start_det;

    always_comb begin
        r_state_d    = r_state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        stop_err     = 1'b0;
        start_det    = 1'b0;

        case (r_state_q)
            R_IDLE: begin
                if (rx_prev_q && !rx) begin
                    start_det = 1'b1;
                    bit_cnt_d = HALF_LOAD;
                    r_state_d = R_START;
                end
            end
            R_START: begin
                if (bit_cnt_q == '0) begin
                    if (!rx) begin
                        bit_cnt_d = FULL_LOAD;
                        bit_idx_d = 3'd0;
                        r_state_d = R_DATA;
                    end else begin
                        // Start bit did not survive to mid-bit: treat it as noise.
                        r_state_d = R_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            R_DATA: begin
                if (bit_cnt_q == '0) begin
                    shreg_d   = {rx, shreg_q[7:1]};
                    bit_cnt_d = FULL_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        r_state_d = R_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            R_STOP: begin
                if (bit_cnt_q == '0) begin
                    if (rx) begin
                        byte_valid_d = 1'b1;
                        r_state_d    = R_IDLE;
                    end else begin
                        stop_err  = 1'b1;
                        r_state_d = R_BRK;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            R_BRK: begin
                if (rx) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Inter-byte idle timer: counts only while the receiver is idle, so a
    // partially received command is abandoned if the sender goes quiet.
    // ------------------------------------------------------------------
    logic [TCW-1:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (byte_valid_q || start_det || (r_state_q != R_IDLE)) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != TO_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command parser
    // ------------------------------------------------------------------
    logic [1:0]  p_state_q, p_state_d;
    logic [26:0] acc_q, acc_d;
    logic [3:0]  dig_cnt_q, dig_cnt_d;
    logic [26:0] freq_q, freq_d;
    logic        freq_valid_q, freq_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        parse_err;
    logic        timeout_hit;
    logic        is_digit;
    logic [26:0] acc_next;

    assign is_digit    = (shreg_q >= 8'h30) && (shreg_q <= 8'h39);
    assign timeout_hit = (p_state_q != P_IDLE) && (idle_cnt_q == TO_MAX) && !byte_valid_q;

    // acc*10 as acc*8 + acc*2. For a validated digit the low nibble of the
    // ASCII code is the digit value. 99,999,999 fits in 27 bits.
    assign acc_next = (acc_q << 3) + (acc_q << 1) + {23'd0, shreg_q[3:0]};

    always_comb begin
        p_state_d    = p_state_q;
        acc_d        = acc_q;
        dig_cnt_d    = dig_cnt_q;
        freq_d       = freq_q;
        freq_valid_d = 1'b0;
        parse_err    = 1'b0;

        if (stop_err) begin
            p_state_d = P_IDLE;
        end else if (byte_valid_q) begin
            case (p_state_q)
                P_IDLE: begin
                    if (shreg_q == 8'h46) begin
                        p_state_d = P_A;
                    end
                end
                P_A: begin
                    if (shreg_q == 8'h41) begin
                        acc_d     = '0;
                        dig_cnt_d = 4'd0;
                        p_state_d = P_DIG;
                    end else if (shreg_q != 8'h46) begin
                        p_state_d = P_IDLE;
                    end
                end
                P_DIG: begin
                    // The first three digits must be '0' (below 100 MHz).
                    if (!is_digit || ((dig_cnt_q < 4'd3) && (shreg_q != 8'h30))) begin
                        parse_err = 1'b1;
                        p_state_d = P_IDLE;
                    end else begin
                        if (dig_cnt_q >= 4'd3) begin
                            acc_d = acc_next;
                        end
                        dig_cnt_d = dig_cnt_q + 1'b1;
                        if (dig_cnt_q == 4'd10) begin
                            p_state_d = P_END;
                        end
                    end
                end
                P_END: begin
                    if (shreg_q == 8'h3B) begin
                        freq_d       = acc_q;
                        freq_valid_d = 1'b1;
                    end else begin
                        parse_err = 1'b1;
                    end
                    p_state_d = P_IDLE;
                end
                default: p_state_d = P_IDLE;
            endcase
        end else if (timeout_hit) begin
            p_state_d = P_IDLE;
        end
    end

    always_comb begin
        frame_err_d = stop_err || parse_err || timeout_hit;
        err_cnt_d   = err_cnt_q;
        if (frame_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= RX_INV;
            sync2_q      <= RX_INV;
            rx_prev_q    <= 1'b1;
            r_state_q    <= R_IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= 3'd0;
            shreg_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            idle_cnt_q   <= '0;
            p_state_q    <= P_IDLE;
            acc_q        <= '0;
            dig_cnt_q    <= 4'd0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            rx_prev_q    <= rx_prev_d;
            r_state_q    <= r_state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            byte_valid_q <= byte_valid_d;
            idle_cnt_q   <= idle_cnt_d;
            p_state_q    <= p_state_d;
            acc_q        <= acc_d;
            dig_cnt_q    <= dig_cnt_d;
            freq_q       <= freq_d;
            freq_valid_q <= freq_valid_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign freq       = {5'd0, freq_q};
    assign freq_valid = freq_valid_q;
    assign frame_err  = frame_err_q;
    assign err_cnt    = err_cnt_q;

    // ------------------------------------------------------------------
    // Band decode
    // ------------------------------------------------------------------
`ifdef EXTAMP_BAND_DECODE_EN
    function automatic logic [3:0] band_of(input logic [26:0] f);
        if      (f >= 27'd1800000  && f <= 27'd2000000)  return 4'd1;
        else if (f >= 27'd3500000  && f <= 27'd4000000)  return 4'd2;
        else if (f >= 27'd5300000  && f <= 27'd5450000)  return 4'd3;
        else if (f >= 27'd7000000  && f <= 27'd7300000)  return 4'd4;
        else if (f >= 27'd10100000 && f <= 27'd10150000) return 4'd5;
        else if (f >= 27'd14000000 && f <= 27'd14350000) return 4'd6;
        else if (f >= 27'd18068000 && f <= 27'd18168000) return 4'd7;
        else if (f >= 27'd21000000 && f <= 27'd21450000) return 4'd8;
        else if (f >= 27'd24890000 && f <= 27'd24990000) return 4'd9;
        else if (f >= 27'd28000000 && f <= 27'd29700000) return 4'd10;
        else if (f >= 27'd50000000 && f <= 27'd54000000) return 4'd11;
        else                                             return 4'd0;
    endfunction

    logic [3:0] band_q, band_d;

    // Loaded from the same acc value and on the same edge as freq.
    always_comb begin
        band_d = band_q;
        if (freq_valid_d) begin
            band_d = band_of(acc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            band_q <= 4'd0;
        end else begin
            band_q <= band_d;
        end
    end

    assign band = band_q;
`else
    assign band = 4'd0;
`endif

endmodule
